// File: rtl/gpu_vram_pkg.sv
// Shared VRAM constants, memory map and enums for the VRAM write path.
package gpu_vram_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_SIZE   = 2304;

  localparam logic [VRAM_ADDR_W-1:0] PMF_BASE  = 12'h000;
  localparam logic [VRAM_ADDR_W-1:0] PMB_BASE  = 12'h200;
  localparam logic [VRAM_ADDR_W-1:0] NTBL_BASE = 12'h400;
  localparam logic [VRAM_ADDR_W-1:0] OBM_BASE  = 12'h800;

  localparam int PMF_SIZE  = 'h200;
  localparam int PMB_SIZE  = 'h200;
  localparam int NTBL_SIZE = 'h400;
  localparam int OBM_SIZE  = 'h100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } fill_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_FILL
  } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU {addr,data} writes until the
// arbiter can hand them to the VRAM port.
module vram_wr_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Sole owner of the VRAM write port: interleaves buffered CPU byte writes
// with a block-fill engine, issuing writes only during the blanking window.
module vram_write_arbiter
  import gpu_vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int VSIZE      = VRAM_SIZE,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writable,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [7:0]        fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic [CW-1:0]     fifo_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VSIZE - 1);

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cur, cur_nxt;
  logic [ADDR_W:0]   rem, rem_nxt;
  logic [7:0]        val, val_nxt;
  grant_t            last_grant;

  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W+7:0] fifo_rd;
  logic              req_c;
  logic              req_f;
  logic              grant_c;
  logic              grant_f;

  assign cpu_ready = !fifo_full;
  assign req_c     = !fifo_empty;
  assign req_f     = (state == RUN);
  assign fill_busy = (state != IDLE);
  assign fill_done = (state == FINISH);

  vram_wr_fifo #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_cpu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cpu_valid && cpu_ready),
    .push_data ({cpu_addr, cpu_data}),
    .pop       (grant_c),
    .pop_data  (fifo_rd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Round-robin grant between CPU and fill; nothing is granted outside blanking.
  always_comb begin
    grant_c = 1'b0;
    grant_f = 1'b0;
    if (writable) begin
      if (req_c && req_f) begin
        grant_c = (last_grant == GNT_FILL);
        grant_f = (last_grant == GNT_CPU);
      end else begin
        grant_c = req_c;
        grant_f = req_f;
      end
    end
  end

  // Fill engine next state: load on start, advance with wrap at VSIZE per granted write.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rem_nxt   = rem;
    val_nxt   = val;
    case (state)
      IDLE: begin
        if (fill_start) begin
          cur_nxt   = fill_base;
          rem_nxt   = fill_len;
          val_nxt   = fill_value;
          state_nxt = (fill_len != '0) ? RUN : FINISH;
        end
      end
      RUN: begin
        if (grant_f) begin
          cur_nxt = (cur == LAST_ADDR) ? '0 : cur + ADDR_W'(1);
          rem_nxt = rem - (ADDR_W+1)'(1);
          if (rem == (ADDR_W+1)'(1)) begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fill engine state and the round-robin history bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      rem        <= '0;
      val        <= '0;
      last_grant <= GNT_FILL;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      rem   <= rem_nxt;
      val   <= val_nxt;
      if (grant_c) begin
        last_grant <= GNT_CPU;
      end else if (grant_f) begin
        last_grant <= GNT_FILL;
      end
    end
  end

  // Registered VRAM port; address/data hold their last value when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= grant_c || grant_f;
      if (grant_c) begin
        vram_addr <= fifo_rd[ADDR_W+7:8];
        vram_data <= fifo_rd[7:0];
      end else if (grant_f) begin
        vram_addr <= cur;
        vram_data <= val;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every write seen on the VRAM port.
module tb_vram_write_arbiter;
  import gpu_vram_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          writable;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [7:0]    fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_data;
  logic [2:0]    fifo_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic wr_prev = 1'b0;

  vram_write_arbiter #(
    .ADDR_W     (AW),
    .VSIZE      (2304),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .writable   (writable),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [7:0] d, input bit last);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    writable   = 1'b0;
    cpu_valid  = 1'b0;
    fill_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic cpu_push(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_data  = d;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] base, input logic [AW:0] len, input logic [7:0] v);
    fill_start = 1'b1;
    fill_base  = base;
    fill_len   = len;
    fill_value = v;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (fill_done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check_output(name, sb.size(), 0);
  endtask

  // Monitor: every VRAM write must be expected, in order, and only after a writable cycle.
  always @(negedge clk) begin
    exp_t e;
    if (fill_done === 1'b1) done_cnt++;
    if (vram_we === 1'b1) begin
      check_output("write_needs_writable", {31'b0, wr_prev}, 1);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", vram_addr, vram_data);
      end else begin
        e = sb.pop_front();
        check_output("write_addr_data", {12'b0, vram_addr, vram_data}, {12'b0, e.addr, e.data});
        if (e.last) check_output("fill_done_with_last", {31'b0, fill_done}, 1);
      end
    end
    wr_prev = writable;
  end

  initial begin
    int n;
    int d0;
    cpu_addr   = '0;
    cpu_data   = '0;
    fill_base  = '0;
    fill_len   = '0;
    fill_value = '0;

    // Reset state, sampled while reset is still asserted.
    rst_n = 1'b0; writable = 1'b0; cpu_valid = 1'b0; fill_start = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_output("rst_vram_we",    {31'b0, vram_we}, 0);
    check_output("rst_vram_addr",  {20'b0, vram_addr}, 0);
    check_output("rst_vram_data",  {24'b0, vram_data}, 0);
    check_output("rst_fill_busy",  {31'b0, fill_busy}, 0);
    check_output("rst_fill_done",  {31'b0, fill_done}, 0);
    check_output("rst_fifo_count", {29'b0, fifo_count}, 0);
    check_output("rst_cpu_ready",  {31'b0, cpu_ready}, 1);
    tick();
    rst_n = 1'b1;

    // Single CPU write: visible two cycles after the push cycle.
    writable = 1'b1;
    tick();
    expect_write(12'h123, 8'hAB, 1'b0);
    cpu_push(12'h123, 8'hAB);
    @(negedge clk);
    check_output("cpu_lat_we_n1", {31'b0, vram_we}, 0);
    check_output("cpu_lat_count", {29'b0, fifo_count}, 1);
    tick();
    @(negedge clk);
    check_output("cpu_lat_we_n2", {31'b0, vram_we}, 1);
    check_output("cpu_lat_count0", {29'b0, fifo_count}, 0);
    tick();
    wait_drain("cpu_single_drain", 10);

    // NTBL clear: 1024 back-to-back writes, done one cycle per byte after start.
    apply_reset();
    writable = 1'b1;
    for (int i = 0; i < 'h400; i++) expect_write(12'h400 + 12'(i), 8'h00, i == 'h3FF);
    d0 = done_cnt;
    apply_stimulus(12'h400, 13'h400, 8'h00);
    wait_done(1100, n);
    check_output("ntbl_done_cycles", n, 'h400);
    wait_drain("ntbl_drain", 10);
    tick();
    check_output("ntbl_done_pulses", done_cnt - d0, 1);
    check_output("ntbl_busy_clear", {31'b0, fill_busy}, 0);

    // Full FIFO while blocked, then CPU/FILL interleave starting with CPU.
    apply_reset();
    for (int i = 0; i < 4; i++) cpu_push(12'h010 + 12'(i), 8'hC0 + 8'(i));
    check_output("fifo_full_count", {29'b0, fifo_count}, 4);
    check_output("fifo_full_ready", {31'b0, cpu_ready}, 0);
    cpu_valid = 1'b1; cpu_addr = 12'h0EE; cpu_data = 8'hEE;
    tick(); tick();
    cpu_valid = 1'b0;
    check_output("fifo_5th_rejected", {29'b0, fifo_count}, 4);
    apply_stimulus(12'h800, 13'd8, 8'h5A);
    expect_write(12'h010, 8'hC0, 1'b0); expect_write(12'h800, 8'h5A, 1'b0);
    expect_write(12'h011, 8'hC1, 1'b0); expect_write(12'h801, 8'h5A, 1'b0);
    expect_write(12'h012, 8'hC2, 1'b0); expect_write(12'h802, 8'h5A, 1'b0);
    expect_write(12'h013, 8'hC3, 1'b0); expect_write(12'h803, 8'h5A, 1'b0);
    expect_write(12'h804, 8'h5A, 1'b0); expect_write(12'h805, 8'h5A, 1'b0);
    expect_write(12'h806, 8'h5A, 1'b0); expect_write(12'h807, 8'h5A, 1'b1);
    d0 = done_cnt;
    writable = 1'b1;
    wait_drain("mix_drain", 40);
    tick(); tick();
    check_output("mix_done_pulses", done_cnt - d0, 1);
    check_output("mix_fifo_empty", {29'b0, fifo_count}, 0);

    // Fill paused by writable 3 on / 5 off; must still be 16 contiguous writes.
    apply_reset();
    for (int i = 0; i < 16; i++) expect_write(12'h100 + 12'(i), 8'h77, i == 15);
    apply_stimulus(12'h100, 13'd16, 8'h77);
    n = 0;
    while (fill_done !== 1'b1 && n < 400) begin
      writable = ((n % 8) < 3);
      tick();
      n++;
    end
    check_output("toggle_done_seen", {31'b0, fill_done}, 1);
    writable = 1'b0;
    wait_drain("toggle_drain", 5);

    // Zero-length fill: done pulse on the cycle after start, no writes.
    apply_reset();
    writable = 1'b1;
    d0 = done_cnt;
    apply_stimulus(12'h400, 13'd0, 8'h33);
    wait_done(10, n);
    check_output("len0_done_cycles", n, 0);
    check_output("len0_busy", {31'b0, fill_busy}, 1);
    tick();
    check_output("len0_done_clear", {31'b0, fill_done}, 0);
    check_output("len0_done_pulses", done_cnt - d0, 1);
    tick(); tick();

    // Wrap at VSIZE rather than at 2^ADDR_W.
    apply_reset();
    writable = 1'b1;
    expect_write(12'h8FE, 8'h44, 1'b0);
    expect_write(12'h8FF, 8'h44, 1'b0);
    expect_write(12'h000, 8'h44, 1'b0);
    expect_write(12'h001, 8'h44, 1'b1);
    apply_stimulus(12'h8FE, 13'd4, 8'h44);
    wait_done(20, n);
    check_output("wrap_done_cycles", n, 4);
    wait_drain("wrap_drain", 5);

    // Reset mid-fill: five writes land, then the fill is aborted silently.
    apply_reset();
    writable = 1'b1;
    for (int i = 0; i < 5; i++) expect_write(12'h200 + 12'(i), 8'h99, 1'b0);
    d0 = done_cnt;
    apply_stimulus(12'h200, 13'd20, 8'h99);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check_output("midrst_busy", {31'b0, fill_busy}, 0);
    check_output("midrst_we", {31'b0, vram_we}, 0);
    check_output("midrst_done", {31'b0, fill_done}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_output("midrst_no_done", done_cnt - d0, 0);
    check_output("midrst_writes", sb.size(), 0);

    // A second start while busy must be ignored.
    apply_reset();
    writable = 1'b1;
    for (int i = 0; i < 4; i++) expect_write(12'h300 + 12'(i), 8'h11, i == 3);
    d0 = done_cnt;
    apply_stimulus(12'h300, 13'd4, 8'h11);
    apply_stimulus(12'h600, 13'd2, 8'h22);
    wait_done(20, n);
    check_output("busy_done_cycles", n, 3);
    for (int i = 0; i < 6; i++) tick();
    check_output("busy_drain", sb.size(), 0);
    check_output("busy_done_pulses", done_cnt - d0, 1);
    check_output("busy_idle", {31'b0, fill_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
